// File: rtl/filter_pkg.sv
// Shared definitions for the stream_filter_sequencer slice.
// Contents:
//   seq_state_e  - sequencer FSM states
//   win_depth    - number of line buffers for a given window size
//   win_radius   - window radius (pixels from centre to edge)
//   clog2_min1   - ceil(log2(n)), never less than 1, used for index widths
package filter_pkg;

  typedef enum logic [0:0] {
    ST_WAIT_SOF = 1'b0,
    ST_ACTIVE   = 1'b1
  } seq_state_e;

  localparam int DEFAULT_FILTER_DIM = 7;

  function automatic int win_depth(input int filter_dim);
    return filter_dim - 1;
  endfunction

  function automatic int win_radius(input int filter_dim);
    return (filter_dim - 1) / 2;
  endfunction

  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    for (int v = 1; v < value; v = v * 2) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/stream_filter_sequencer_if.sv
// Beat / line-buffer / window bundle between the video stream side and the
// stream_filter_sequencer.
//   beat, beat_user, beat_last : accepted input beat and its tuser/tlast
//   lb_wr_en, lb_addr, lb_wr_sel : line-buffer write controls
//   win_valid, win_sof, win_eol  : window markers aligned with the beat
// master drives the beat and consumes the controls; slave is the sequencer.
interface stream_filter_sequencer_if
  import filter_pkg::*;
#(
  parameter int CNT_W    = 12,
  parameter int LB_SEL_W = clog2_min1(win_depth(DEFAULT_FILTER_DIM))
);
  logic                beat;
  logic                beat_user;
  logic                beat_last;
  logic                lb_wr_en;
  logic [CNT_W-1:0]    lb_addr;
  logic [LB_SEL_W-1:0] lb_wr_sel;
  logic                win_valid;
  logic                win_sof;
  logic                win_eol;

  modport master (
    output beat, beat_user, beat_last,
    input  lb_wr_en, lb_addr, lb_wr_sel, win_valid, win_sof, win_eol
  );

  modport slave (
    input  beat, beat_user, beat_last,
    output lb_wr_en, lb_addr, lb_wr_sel, win_valid, win_sof, win_eol
  );
endinterface

// File: rtl/filter_pos_counter.sv
// Column/row/line-buffer-slot tracking for the filter sequencer.
// Inputs:  clk, reset, adv (beat is a frame pixel), restart (beat is a new
//          pixel (0,0)), clear (drop position, bad cfg), last (tlast),
//          w/h (effective frame geometry for this beat).
// Outputs: col/row/sel (effective position of this beat), col_at_end
//          (col == W-1), line_end, frame_end (unqualified by adv).
module filter_pos_counter #(
  parameter int CNT_W    = 12,
  parameter int LB_SEL_W = 3,
  parameter int WIN_D    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                adv,
  input  logic                restart,
  input  logic                clear,
  input  logic                last,
  input  logic [CNT_W-1:0]    w,
  input  logic [CNT_W-1:0]    h,
  output logic [CNT_W-1:0]    col,
  output logic [CNT_W-1:0]    row,
  output logic [LB_SEL_W-1:0] sel,
  output logic                col_at_end,
  output logic                line_end,
  output logic                frame_end
);

  logic [CNT_W-1:0]    col_r;
  logic [CNT_W-1:0]    row_r;
  logic [LB_SEL_W-1:0] sel_r;

  // A restarting beat is treated as pixel (0,0) in slot 0 regardless of history.
  assign col        = restart ? {CNT_W{1'b0}} : col_r;
  assign row        = restart ? {CNT_W{1'b0}} : row_r;
  assign sel        = restart ? {LB_SEL_W{1'b0}} : sel_r;
  assign col_at_end = (col == (w - CNT_W'(1)));
  assign line_end   = last || col_at_end;
  assign frame_end  = line_end && (row == (h - CNT_W'(1)));

  // Position registers: advance per pixel, wrap at line and frame ends.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col_r <= {CNT_W{1'b0}};
      row_r <= {CNT_W{1'b0}};
      sel_r <= {LB_SEL_W{1'b0}};
    end else if (adv) begin
      if (line_end) begin
        col_r <= {CNT_W{1'b0}};
        if (frame_end) begin
          row_r <= {CNT_W{1'b0}};
          sel_r <= {LB_SEL_W{1'b0}};
        end else begin
          row_r <= row + CNT_W'(1);
          sel_r <= (sel == LB_SEL_W'(WIN_D - 1)) ? {LB_SEL_W{1'b0}} : sel + LB_SEL_W'(1);
        end
      end else begin
        col_r <= col + CNT_W'(1);
        row_r <= row;
        sel_r <= sel;
      end
    end else begin
      col_r <= col_r;
      row_r <= row_r;
      sel_r <= sel_r;
    end
  end

endmodule

// File: rtl/stream_filter_sequencer.sv
// Control sequencer for the stream_video_filter datapath.
// Tracks accepted beats against the latched frame geometry, drives the
// line-buffer write/rotation controls and zero-latency window markers, and
// flags framing errors (resynchronising on SOF).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   cfg_width, cfg_height : frame geometry, latched on each accepted SOF
//   bus (slave)           : beat in, line-buffer controls and window markers out
//   frame_done, err_*     : one-cycle pulses, the cycle after the causing beat
//   busy                  : sequencer is inside a frame
module stream_filter_sequencer
  import filter_pkg::*;
#(
  parameter int FILTER_DIM = 7,
  parameter int CNT_W      = 12,
  parameter int LB_SEL_W   = clog2_min1(FILTER_DIM - 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CNT_W-1:0]           cfg_width,
  input  logic [CNT_W-1:0]           cfg_height,
  stream_filter_sequencer_if.slave   bus,
  output logic                       frame_done,
  output logic                       err_cfg,
  output logic                       err_sof,
  output logic                       err_eol_early,
  output logic                       err_eol_late,
  output logic                       busy
);

  localparam int               WIN_D = win_depth(FILTER_DIM);
  localparam logic [CNT_W-1:0] DIM_C = CNT_W'(FILTER_DIM);
  localparam logic [CNT_W-1:0] D_C   = CNT_W'(WIN_D);

  seq_state_e          state_r;
  seq_state_e          state_nxt_s;
  logic [CNT_W-1:0]    w_r;
  logic [CNT_W-1:0]    h_r;
  logic                sof_s;
  logic                cfg_ok_s;
  logic                drop_s;
  logic                pix_s;
  logic [CNT_W-1:0]    w_eff_s;
  logic [CNT_W-1:0]    h_eff_s;
  logic [CNT_W-1:0]    col_s;
  logic [CNT_W-1:0]    row_s;
  logic [LB_SEL_W-1:0] sel_s;
  logic                col_at_end_s;
  logic                line_end_s;
  logic                frame_end_s;
  logic                early_s;
  logic                late_s;
  logic                wr_en_s;
  logic                win_valid_s;
  logic                win_sof_s;
  logic                win_eol_s;

  // Reset wins over a concurrent beat, so every beat qualifier is gated by it.
  assign sof_s    = bus.beat && bus.beat_user && !reset;
  assign cfg_ok_s = (cfg_width >= DIM_C) && (cfg_height >= DIM_C);
  assign drop_s   = sof_s && !cfg_ok_s;
  // A beat is a frame pixel when it is a good SOF, or any non-SOF beat while ACTIVE.
  assign pix_s    = bus.beat && !reset && (sof_s ? cfg_ok_s : (state_r == ST_ACTIVE));
  // The SOF beat itself already uses the geometry being latched.
  assign w_eff_s  = sof_s ? cfg_width  : w_r;
  assign h_eff_s  = sof_s ? cfg_height : h_r;

  filter_pos_counter #(
    .CNT_W    (CNT_W),
    .LB_SEL_W (LB_SEL_W),
    .WIN_D    (WIN_D)
  ) u_pos (
    .clk        (clk),
    .reset      (reset),
    .adv        (pix_s),
    .restart    (sof_s),
    .clear      (drop_s),
    .last       (bus.beat_last),
    .w          (w_eff_s),
    .h          (h_eff_s),
    .col        (col_s),
    .row        (row_s),
    .sel        (sel_s),
    .col_at_end (col_at_end_s),
    .line_end   (line_end_s),
    .frame_end  (frame_end_s)
  );

  assign early_s = pix_s && bus.beat_last && !col_at_end_s;
  assign late_s  = pix_s && !bus.beat_last && col_at_end_s;

  // Output decode: write every pixel, mark windows only once D rows/cols are buffered.
  always_comb begin
    wr_en_s     = 1'b0;
    win_valid_s = 1'b0;
    win_sof_s   = 1'b0;
    win_eol_s   = 1'b0;
    if (pix_s) begin
      wr_en_s     = 1'b1;
      win_valid_s = !early_s && (col_s >= D_C) && (row_s >= D_C);
      win_sof_s   = win_valid_s && (col_s == D_C) && (row_s == D_C);
      win_eol_s   = win_valid_s && col_at_end_s;
    end else begin
      wr_en_s     = 1'b0;
      win_valid_s = 1'b0;
      win_sof_s   = 1'b0;
      win_eol_s   = 1'b0;
    end
  end

  assign bus.lb_wr_en  = wr_en_s;
  assign bus.lb_addr   = col_s;
  assign bus.lb_wr_sel = sel_s;
  assign bus.win_valid = win_valid_s;
  assign bus.win_sof   = win_sof_s;
  assign bus.win_eol   = win_eol_s;
  assign busy          = (state_r == ST_ACTIVE);

  // Next-state: a bad SOF always parks in WAIT_SOF; a pixel stays ACTIVE until frame end.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_WAIT_SOF, ST_ACTIVE: begin
        if (drop_s) begin
          state_nxt_s = ST_WAIT_SOF;
        end else if (pix_s) begin
          state_nxt_s = frame_end_s ? ST_WAIT_SOF : ST_ACTIVE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = ST_WAIT_SOF;
    endcase
  end

  // State, latched geometry and registered event pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_WAIT_SOF;
      w_r           <= {CNT_W{1'b0}};
      h_r           <= {CNT_W{1'b0}};
      frame_done    <= 1'b0;
      err_cfg       <= 1'b0;
      err_sof       <= 1'b0;
      err_eol_early <= 1'b0;
      err_eol_late  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (sof_s) begin
        w_r <= cfg_width;
        h_r <= cfg_height;
      end else begin
        w_r <= w_r;
        h_r <= h_r;
      end
      frame_done    <= pix_s && frame_end_s;
      err_cfg       <= drop_s;
      err_sof       <= sof_s && (state_r == ST_ACTIVE);
      err_eol_early <= early_s;
      err_eol_late  <= late_s;
    end
  end

endmodule

// File: tb/tb_stream_filter_sequencer.sv
// Self-checking bench for stream_filter_sequencer (FILTER_DIM=7, W=20, H=10).
// A position-level model predicts every output per cycle; scenario-level
// literal expectations pin the model's aggregate behaviour.
module tb_stream_filter_sequencer;
  import filter_pkg::*;

  localparam int FD = 7;
  localparam int CW = 12;
  localparam int SW = 3;
  localparam int DD = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] cfg_width = 12'd20;
  logic [CW-1:0] cfg_height = 12'd10;
  logic          frame_done, err_cfg, err_sof, err_eol_early, err_eol_late, busy;

  stream_filter_sequencer_if #(.CNT_W(CW), .LB_SEL_W(SW)) bus ();

  stream_filter_sequencer #(.FILTER_DIM(FD), .CNT_W(CW), .LB_SEL_W(SW)) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_width     (cfg_width),
    .cfg_height    (cfg_height),
    .bus           (bus),
    .frame_done    (frame_done),
    .err_cfg       (err_cfg),
    .err_sof       (err_sof),
    .err_eol_early (err_eol_early),
    .err_eol_late  (err_eol_late),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // model state: frame position in plain integers; slot is row mod D
  bit m_act = 1'b0;
  int m_col = 0, m_row = 0, m_w = 0, m_h = 0;
  // expectations for the current cycle
  bit chk_en = 1'b0;
  bit e_wr, e_valid, e_sof, e_eol, e_busy;
  int e_addr, e_sel;
  bit e_done, e_cfg, e_serr, e_early, e_late;
  bit p_done, p_cfg, p_serr, p_early, p_late;
  // stimulus tags and statistics
  int cur_row = -1, cur_col = -1, cur_idx = -1, last_idx = -1;
  int s_valid, s_eol, s_sof, s_sof_idx, s_done, s_done_after;
  int s_cfg, s_serr, s_early, s_late, s_wr, s_gap_viol;
  int sel_seq[10];

  task automatic clear_stats();
    s_valid = 0; s_eol = 0; s_sof = 0; s_sof_idx = -1; s_done = 0; s_done_after = -1;
    s_cfg = 0; s_serr = 0; s_early = 0; s_late = 0; s_wr = 0; s_gap_viol = 0;
    for (int i = 0; i < 10; i++) sel_seq[i] = -1;
  endtask

  // One clock cycle of stimulus plus the model's prediction for it.
  task automatic step(input bit b, input bit u, input bit l, input bit r,
                      input int cw, input int ch, input int row, input int col, input int idx);
    bit early;
    @(posedge clk);
    #2;
    bus.beat = b; bus.beat_user = u; bus.beat_last = l; reset = r;
    cfg_width = CW'(cw); cfg_height = CW'(ch);
    cur_row = row; cur_col = col; cur_idx = idx;
    e_done = p_done; e_cfg = p_cfg; e_serr = p_serr; e_early = p_early; e_late = p_late;
    p_done = 0; p_cfg = 0; p_serr = 0; p_early = 0; p_late = 0;
    e_busy = m_act;
    e_wr = 0; e_valid = 0; e_sof = 0; e_eol = 0; e_addr = 0; e_sel = 0;
    if (r) begin
      m_act = 0; m_col = 0; m_row = 0; m_w = 0; m_h = 0;
    end else if (b) begin
      bit pixel;
      pixel = m_act;
      if (u) begin
        p_serr = m_act;
        m_w = cw; m_h = ch;
        m_col = 0; m_row = 0;
        if (cw < FD || ch < FD) begin
          p_cfg = 1; m_act = 0; pixel = 0;
        end else begin
          pixel = 1;
        end
      end
      if (pixel) begin
        e_wr = 1; e_addr = m_col; e_sel = m_row % DD;
        early = l && (m_col != m_w - 1);
        p_early = early;
        p_late = !l && (m_col == m_w - 1);
        e_valid = !early && m_col >= DD && m_row >= DD;
        e_sof = e_valid && m_col == DD && m_row == DD;
        e_eol = e_valid && m_col == m_w - 1;
        m_act = 1;
        if (l || m_col == m_w - 1) begin
          m_col = 0;
          if (m_row == m_h - 1) begin
            p_done = 1; m_act = 0; m_row = 0;
          end else begin
            m_row = m_row + 1;
          end
        end else begin
          m_col = m_col + 1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 20, 10, -1, -1, -1);
  endtask

  // Drive one 20x10 frame with optional early EOL, missing tlast, abort, reset, gaps.
  task automatic send_frame(input int early_row, input int early_col, input int late_row,
                            input int abort_at, input int rst_at, input bit gaps);
    int idx;
    idx = 0;
    for (int row = 0; row < 10; row++) begin
      int len;
      len = (row == early_row) ? early_col + 1 : 20;
      for (int col = 0; col < len; col++) begin
        if (idx == abort_at) return;
        while (gaps && $urandom_range(0, 2) == 0) idle(1);
        step(1, idx == 0, (col == len - 1) && (row != late_row), idx == rst_at,
             20, 10, row, col, idx);
        idx++;
        if (idx - 1 == rst_at) return;
      end
    end
  endtask

  // Per-cycle compare against the model, plus statistics gathering.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("lb_wr_en", bus.lb_wr_en, e_wr);
      if (e_wr) begin
        chk("lb_addr", bus.lb_addr, e_addr);
        chk("lb_wr_sel", bus.lb_wr_sel, e_sel);
      end
      chk("win_valid", bus.win_valid, e_valid);
      chk("win_sof", bus.win_sof, e_sof);
      chk("win_eol", bus.win_eol, e_eol);
      chk("busy", busy, e_busy);
      chk("frame_done", frame_done, e_done);
      chk("err_cfg", err_cfg, e_cfg);
      chk("err_sof", err_sof, e_serr);
      chk("err_eol_early", err_eol_early, e_early);
      chk("err_eol_late", err_eol_late, e_late);
      if (bus.win_valid) s_valid++;
      if (bus.win_eol) s_eol++;
      if (bus.win_sof) begin s_sof++; s_sof_idx = cur_idx; end
      if (frame_done) begin s_done++; s_done_after = last_idx; end
      if (err_cfg) s_cfg++;
      if (err_sof) s_serr++;
      if (err_eol_early) s_early++;
      if (err_eol_late) s_late++;
      if (bus.lb_wr_en) s_wr++;
      if (bus.lb_wr_en && cur_col == 0 && cur_row >= 0 && cur_row < 10)
        sel_seq[cur_row] = int'(bus.lb_wr_sel);
      if (cur_idx < 0 && (bus.lb_wr_en || bus.win_valid || bus.win_sof || bus.win_eol))
        s_gap_viol++;
      if (cur_idx >= 0) last_idx = cur_idx;
    end
  end

  int exp_sel[10] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3};

  initial begin
    bus.beat = 1'b0; bus.beat_user = 1'b0; bus.beat_last = 1'b0;
    clear_stats();
    step(0, 0, 0, 1, 20, 10, -1, -1, -1);
    chk_en = 1'b1;
    step(0, 0, 0, 1, 20, 10, -1, -1, -1);
    idle(1);
    @(negedge clk); #1;
    chk("reset_busy", busy, 0);
    chk("reset_addr", bus.lb_addr, 0);
    chk("reset_sel", bus.lb_wr_sel, 0);

    // 1: clean frame
    clear_stats();
    send_frame(-1, -1, -1, -1, -1, 0);
    idle(2);
    chk("s1_valid_cnt", s_valid, 56);
    chk("s1_eol_cnt", s_eol, 4);
    chk("s1_sof_cnt", s_sof, 1);
    chk("s1_sof_beat", s_sof_idx, 126);
    chk("s1_done_cnt", s_done, 1);
    chk("s1_done_after", s_done_after, 199);
    for (int i = 0; i < 10; i++) chk("s1_row_sel", sel_seq[i], exp_sel[i]);

    // 2: random gaps
    clear_stats();
    send_frame(-1, -1, -1, -1, -1, 1);
    idle(2);
    chk("s2_valid_cnt", s_valid, 56);
    chk("s2_eol_cnt", s_eol, 4);
    chk("s2_sof_beat", s_sof_idx, 126);
    chk("s2_done_after", s_done_after, 199);
    chk("s2_gap_outputs", s_gap_viol, 0);

    // 3: early EOL at (2,15)
    clear_stats();
    send_frame(2, 15, -1, -1, -1, 0);
    idle(2);
    chk("s3_early_cnt", s_early, 1);
    chk("s3_row3_sel", sel_seq[3], 3);
    chk("s3_done_after", s_done_after, 195);

    // 4: missing tlast at (8,19)
    clear_stats();
    send_frame(-1, -1, 8, -1, -1, 0);
    idle(2);
    chk("s4_late_cnt", s_late, 1);
    chk("s4_row9_sel", sel_seq[9], 3);
    chk("s4_done_cnt", s_done, 1);

    // 5: SOF at (4,5) restarts the frame
    send_frame(-1, -1, -1, 85, -1, 0);
    clear_stats();
    send_frame(-1, -1, -1, -1, -1, 0);
    idle(2);
    chk("s5_sof_err_cnt", s_serr, 1);
    chk("s5_done_cnt", s_done, 1);
    chk("s5_done_after", s_done_after, 199);
    chk("s5_valid_cnt", s_valid, 56);

    // 6a: too-narrow geometry at SOF
    clear_stats();
    step(1, 1, 0, 0, 5, 10, 0, 0, 0);
    step(1, 0, 0, 0, 20, 10, 0, 1, 1);
    step(1, 0, 0, 0, 20, 10, 0, 2, 2);
    idle(1);
    @(negedge clk); #1;
    chk("s6_cfg_cnt", s_cfg, 1);
    chk("s6_cfg_wr", s_wr, 0);
    chk("s6_cfg_busy", busy, 0);

    // 6b: reset concurrent with beat 50
    clear_stats();
    send_frame(-1, -1, -1, -1, 50, 0);
    @(negedge clk); #1;
    chk("s6_rst_wr", s_wr, 50);
    idle(1);
    @(negedge clk); #1;
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_addr", bus.lb_addr, 0);
    chk("s6_rst_sel", bus.lb_wr_sel, 0);
    chk("s6_rst_err", s_serr + s_early + s_late + s_cfg + s_done, 0);

    // recovery after reset
    clear_stats();
    send_frame(-1, -1, -1, -1, -1, 0);
    idle(2);
    chk("s6_recover_done", s_done, 1);
    chk("s6_recover_valid", s_valid, 56);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
